// File: rtl/display_pkg.sv
// Shared types and helpers for the framebuffer scanout stage.
package display_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } fetch_state_t;

  // Replicate the top bits so full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Simple dual-port line buffer: one write port for the fetch side and one
// synchronous read port for the display side, shaped for block-RAM inference.
module line_buffer_dp #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Write port and registered read port; no reset so the array maps to BRAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/display_scanout.sv
// Prefetches each active line from the framebuffer into a ping-pong line buffer
// one line ahead of display, then emits RGB888 aligned with delayed syncs.
module display_scanout
  import display_pkg::*;
#(
  parameter int                CORDW   = 16,
  parameter int                H_RES   = H_RES_DEF,
  parameter int                V_RES   = V_RES_DEF,
  parameter int                ADDR_W  = 24,
  parameter logic [ADDR_W-1:0] FB_BASE = '0,
  parameter int                BURST   = 8
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    line,
  input  logic                    de,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [15:0]             mem_rsp_data,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de_out,
  output logic                    underrun
);

  localparam int PW   = $clog2(H_RES);
  localparam int AW   = PW + 1;
  localparam int PTRW = $clog2(H_RES + 1);
  localparam int CW   = $clog2(BURST + 1);
  localparam logic signed [CORDW-1:0] LAST_Y = CORDW'(V_RES - 1);

  fetch_state_t      r_state;
  logic [PTRW-1:0]   r_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_bank;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_valid;
  logic              r_underrun;

  logic              w_line_fetch;
  logic              w_trig;
  logic [ADDR_W-1:0] w_next_base;
  logic              w_next_bank;
  logic [PTRW-1:0]   w_ptr_inc;
  logic              w_burst_end;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [15:0]       w_rdata;
  logic              w_unused_sx;

  // Line n prefetches line n+1; the last active line has nothing to prefetch.
  assign w_line_fetch = line && !sy[CORDW-1] && (sy < LAST_Y);
  assign w_trig       = frame || w_line_fetch;
  assign w_next_base  = frame ? FB_BASE : r_line_base + ADDR_W'(H_RES);
  assign w_next_bank  = frame ? 1'b0 : ~sy[0];
  assign w_ptr_inc    = r_ptr + PTRW'(1);
  assign w_burst_end  = (r_cnt == CW'(BURST - 1));
  assign w_we         = (r_state == RSP) && mem_rsp_valid;
  assign w_waddr      = {r_bank, r_ptr[PW-1:0]};
  assign w_raddr      = {sy[0], sx[PW-1:0]};
  assign w_unused_sx  = &{1'b0, sx[CORDW-1:PW]};

  // Fetch FSM: one burst request outstanding at a time, late triggers dropped.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_bank      <= 1'b0;
      r_line_base <= FB_BASE;
      r_req_addr  <= '0;
      r_req_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_trig && (r_state != IDLE)) begin
        r_underrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_state     <= REQ;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_bank      <= w_next_bank;
            r_line_base <= w_next_base;
            r_req_addr  <= w_next_base;
            r_req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= RSP;
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            r_ptr <= w_ptr_inc;
            r_cnt <= r_cnt + CW'(1);
            if (w_burst_end) begin
              r_cnt <= '0;
              if (w_ptr_inc == PTRW'(H_RES)) begin
                r_state <= IDLE;
              end else begin
                r_state     <= REQ;
                r_req_valid <= 1'b1;
                r_req_addr  <= r_line_base + ADDR_W'(w_ptr_inc);
              end
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  line_buffer_dp #(
    .AW(AW),
    .DW(16)
  ) u_line_buffer (
    .clk    (clk_pix),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(mem_rsp_data),
    .i_re   (de),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  logic        r_de_d1, r_de_d2;
  logic        r_hs_d1, r_hs_d2;
  logic        r_vs_d1, r_vs_d2;
  logic [23:0] r_rgb;

  // Two-stage display pipeline matching the buffer read latency.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_de_d1 <= 1'b0;
      r_de_d2 <= 1'b0;
      r_hs_d1 <= 1'b1;
      r_hs_d2 <= 1'b1;
      r_vs_d1 <= 1'b1;
      r_vs_d2 <= 1'b1;
      r_rgb   <= 24'h000000;
    end else begin
      r_de_d1 <= de;
      r_de_d2 <= r_de_d1;
      r_hs_d1 <= hsync_in;
      r_hs_d2 <= r_hs_d1;
      r_vs_d1 <= vsync_in;
      r_vs_d2 <= r_vs_d1;
      r_rgb   <= r_de_d1 ? rgb565_to_rgb888(w_rdata) : 24'h000000;
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign underrun      = r_underrun;
  assign r             = r_rgb[23:16];
  assign g             = r_rgb[15:8];
  assign b             = r_rgb[7:0];
  assign de_out        = r_de_d2;
  assign hsync         = r_hs_d2;
  assign vsync         = r_vs_d2;

endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout with a burst memory model on the falling edge.
module tb_display_scanout;

  logic               clk_pix = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame = 1'b0, line = 1'b0, de = 1'b0;
  logic               hsync_in = 1'b1, vsync_in = 1'b1;
  logic signed [15:0] sx = 16'sd0, sy = 16'sd0;
  logic               mem_req_valid;
  logic               mem_req_ready = 1'b0;
  logic [23:0]        mem_req_addr;
  logic               mem_rsp_valid = 1'b0;
  logic [15:0]        mem_rsp_data = 16'h0000;
  logic [7:0]         r, g, b;
  logic               hsync, vsync, de_out, underrun;

  int checks = 0;
  int errors = 0;

  int          req_count = 0;
  logic [23:0] req_log [0:127];
  int          hold_cnt = 0;
  int          rsp_lat = 0;
  int          rsp_left = 0;
  int          rsp_wait = 0;
  int          rsp_total = 0;
  logic [23:0] rsp_addr = 24'h0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [23:0] prev_addr = 24'h0;

  always #5 clk_pix = ~clk_pix;

  display_scanout #(.FB_BASE(24'h001000)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .line(line), .de(de),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .sx(sx), .sy(sy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .r(r), .g(g), .b(b), .hsync(hsync),
    .vsync(vsync), .de_out(de_out), .underrun(underrun)
  );

  // Memory model: returns addr[15:0] per word, logs accepted requests.
  always @(negedge clk_pix) begin
    if (!rst_n) begin
      rsp_left      = 0;
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      prev_valid    = 1'b0;
      prev_ready    = 1'b0;
    end else begin
      if (rsp_left > 0 && rsp_wait > 0) begin
        rsp_wait--;
        mem_rsp_valid = 1'b0;
      end else if (rsp_left > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_addr[15:0];
        rsp_addr++;
        rsp_left--;
        rsp_total++;
      end else begin
        mem_rsp_valid = 1'b0;
      end
      if (prev_valid && prev_ready) begin
        if (req_count < 128) req_log[req_count] = prev_addr;
        req_count++;
        rsp_left = 8;
        rsp_wait = rsp_lat;
        rsp_addr = prev_addr;
      end
      if (mem_req_valid && hold_cnt > 0) begin
        mem_req_ready = 1'b0;
        hold_cnt--;
      end else begin
        mem_req_ready = 1'b1;
      end
      prev_valid = mem_req_valid;
      prev_ready = mem_req_ready;
      prev_addr  = mem_req_addr;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_pix);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    cyc(1);
    frame = 1'b0;
  endtask

  task automatic pulse_line(input int y);
    sy   = 16'(y);
    line = 1'b1;
    cyc(1);
    line = 1'b0;
  endtask

  task automatic wait_reqs(input int target, input int budget, input string name);
    int n = 0;
    while (!(req_count >= target && rsp_left == 0 && !mem_rsp_valid) && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout: req_count=%0d required %0d", name, req_count, target);
    end
    cyc(2);
  endtask

  task automatic pixel(input string name, input int x, input int y, input logic d,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    sx = 16'(x);
    sy = 16'(y);
    de = d;
    cyc(1);
    de = 1'b0;
    cyc(1);
    checks++;
    if ({r, g, b, de_out} !== {er, eg, eb, d}) begin
      errors++;
      $display("FAIL %s: rgb=%h_%h_%h de_out=%b required %h_%h_%h de_out=%b",
               name, r, g, b, de_out, er, eg, eb, d);
    end
  endtask

  task automatic check_addrs(input string name, input logic [23:0] base);
    int bad = -1;
    for (int i = 0; i < 80; i++) begin
      if (bad < 0 && req_log[i] !== base + 24'(8 * i)) bad = i;
    end
    checks++;
    if (req_count != 80) begin
      errors++;
      $display("FAIL %s_count: got %0d required 80", name, req_count);
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_addr[%0d]: got %h required %h", name, bad, req_log[bad], base + 24'(8 * bad));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({mem_req_valid, mem_req_addr, r, g, b, de_out, hsync, vsync, underrun} !==
        {1'b0, 24'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: valid=%b addr=%h rgb=%h_%h_%h de=%b hs=%b vs=%b und=%b required 0 0 0_0_0 0 1 1 0",
               name, mem_req_valid, mem_req_addr, r, g, b, de_out, hsync, vsync, underrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    cyc(3);
    check_reset_outputs("reset_state");
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_frame_fetch();
    rsp_lat = 0;
    req_count = 0;
    pulse_frame();
    wait_reqs(80, 3000, "frame_fetch");
    check_addrs("frame", 24'h001000);
    pixel("frame_px5", 5, 0, 1'b1, 8'h10, 8'h00, 8'h29);
    pixel("frame_px639", 639, 0, 1'b1, 8'h10, 8'h4D, 8'hFF);
    pixel("blank_px", 5, 0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_sync_delay();
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    cyc(1);
    checks++;
    if ({hsync, vsync} !== 2'b11) begin
      errors++;
      $display("FAIL sync_d1: got %b%b required 11", hsync, vsync);
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    cyc(1);
    checks++;
    if ({hsync, vsync} !== 2'b00) begin
      errors++;
      $display("FAIL sync_d2: got %b%b required 00", hsync, vsync);
    end
    cyc(2);
  endtask

  task automatic test_line_fetch();
    req_count = 0;
    pulse_line(0);
    wait_reqs(80, 3000, "line_fetch");
    check_addrs("line1", 24'h001280);
    pixel("line1_px0", 0, 1, 1'b1, 8'h10, 8'h51, 8'h00);
    pixel("bank0_kept", 5, 0, 1'b1, 8'h10, 8'h00, 8'h29);
    req_count = 0;
    pulse_line(479);
    cyc(100);
    checks++;
    if (req_count != 0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_line_nofetch: reqs=%0d valid=%b required 0 0", req_count, mem_req_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    req_count = 0;
    hold_cnt = 10;
    pulse_line(1);
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 24'h001500 || req_count != 0) bad++;
      cyc(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles, valid=%b addr=%h required 1 001500", bad, mem_req_valid, mem_req_addr);
    end
    wait_reqs(80, 3000, "bp_fetch");
    check_addrs("bp", 24'h001500);
    pixel("bp_px7", 7, 2, 1'b1, 8'h10, 8'hA2, 8'h39);
  endtask

  task automatic test_underrun();
    rsp_lat = 20;
    req_count = 0;
    pulse_line(2);
    cyc(50);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pre: got %b required 0", underrun);
    end
    pulse_line(3);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set: got %b required 1", underrun);
    end
    wait_reqs(80, 8000, "underrun_fetch");
    cyc(20);
    check_addrs("underrun", 24'h001780);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: got %b required 1", underrun);
    end
    pixel("underrun_px3", 3, 3, 1'b1, 8'h10, 8'hF3, 8'h18);
    rsp_lat = 0;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    req_count = 0;
    rsp_total = 0;
    pulse_frame();
    while (rsp_total < 3 && n < 100) begin
      cyc(1);
      n++;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_burst_reset");
    cyc(3);
    rst_n = 1'b1;
    req_count = 0;
    cyc(100);
    checks++;
    if (req_count != 0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: reqs=%0d valid=%b required 0 0", req_count, mem_req_valid);
    end
    pulse_frame();
    wait_reqs(80, 3000, "refetch");
    check_addrs("refetch", 24'h001000);
    pixel("refetch_px5", 5, 0, 1'b1, 8'h10, 8'h00, 8'h29);
    hold_cnt = 5;
    pulse_frame();
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_before_reset: valid=%b required 1", mem_req_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_reset_async: valid=%b required 0", mem_req_valid);
    end
    cyc(2);
    hold_cnt = 0;
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_frame_fetch();
    test_sync_delay();
    test_line_fetch();
    test_backpressure();
    test_underrun();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scanout.md
# display_scanout

Framebuffer scanout stage between the SDRAM framebuffer and the DVI encoder, downstream of the 640x480p60 display timing generator. It prefetches each active line as RGB565 words from memory into a ping-pong line buffer, one line ahead of display. It then emits 8-bit-per-channel RGB aligned with delayed sync and data-enable signals. A sticky flag reports any fetch that fails to finish in time.

## Interface
- CORDW, 16, signed coordinate width (matches timing generator)
- H_RES, 640, active pixels per line; multiple of BURST
- V_RES, 480, active lines
- ADDR_W, 24, memory word-address width
- FB_BASE, 0, word address of pixel (0,0)
- BURST, 8, words per memory read request

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- frame, line, de  in  1  timing strobes, registered and aligned with sx/sy
- hsync_in, vsync_in  in  1  timing syncs, aligned with de
- sx, sy  in  CORDW  signed screen position
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  request accepted
- mem_req_addr  out  ADDR_W  burst start word address
- mem_rsp_valid  in  1  one data word valid; no backpressure
- mem_rsp_data  in  16  RGB565 word, in request order
- r, g, b  out  8  pixel colour
- hsync, vsync, de_out  out  1  syncs/enable, delayed to match r/g/b
- underrun  out  1  sticky late-fetch flag

## Operation
- Reset values:
  - mem_req_valid=0, mem_req_addr=0.
  - r=g=b=0, de_out=0, hsync=vsync=1, underrun=0.
  - FSM in IDLE; line-base register = FB_BASE.
- Fetch triggers:
  - frame: fetch line 0 into bank 0; line-base := FB_BASE.
  - line with 0 ≤ sy < V_RES-1: fetch line sy+1 into bank (sy+1)[0]; line-base += H_RES.
  - line with sy = V_RES-1: no fetch.
- FSM:
  - IDLE -> REQ on trigger; word pointer := 0.
  - REQ: mem_req_valid=1, mem_req_addr = line-base + pointer. On valid&&ready -> RSP.
  - RSP: each mem_rsp_valid writes data to bank[pointer] and increments pointer. After BURST words -> REQ, or -> IDLE if pointer = H_RES.
- Handshake:
  - In REQ, valid and addr are held stable until ready.
  - valid never depends combinationally on ready.
  - Exactly one request is outstanding at a time.
- Trigger while not IDLE: underrun := 1, the trigger is dropped, and the current fetch completes unchanged. underrun clears only on reset.
- Address arithmetic wraps modulo 2^ADDR_W.
- Display path:
  - Read address is {sy[0], sx[..]}, issued only when de=1.
  - Expansion: r = {d[15:11], d[15:13]}; g = {d[10:5], d[10:9]}; b = {d[4:0], d[4:2]}.
  - When delayed de = 0, r=g=b=0.
- rst_n asserted mid-burst: the FSM returns to IDLE immediately. The memory shares rst_n, so no stale responses arrive after release.

## Timing
- Pixel latency is 2 cycles: sx/de at cycle n -> RAM data at n+1 -> r/g/b/de_out at n+2.
- hsync, vsync and de_out are delayed 2 cycles through a register pipeline.
- A buffer write at cycle n is readable at n+1. The same-address read/write conflict cannot occur (different banks).
- Budget: one full line period (800 cycles) per fetch of H_RES/BURST = 80 requests.

## Structure
- Package display_pkg:
  - fetch_state_t enum {IDLE, REQ, RSP}.
  - rgb565_to_rgb888 function.
  - Shared H_RES/V_RES defaults.
- Sub-module line_buffer_dp: simple dual-port RAM, 2*H_RES x 16.
  - One write port (fetch side) and one synchronous-read port (display side).
  - Written for BRAM inference.
- FSM, pointers and the display pipeline live in display_scanout.

## Test plan
- **Reset:** rst_n=0 at any cycle -> mem_req_valid=0, r/g/b=0, de_out=0, hsync=vsync=1, underrun=0, asynchronously.
- **Frame fetch** (FB_BASE=0x1000, ready=1, model returns addr[15:0]) -> 80 requests at 0x1000, 0x1008, …, 0x1278. Then sy=0, sx=5 gives r=0x10, g=0x00, b=0x29 two cycles later with de_out=1.
- **Line fetch:** line at sy=0 -> first request address 0x1280, written to bank 1. Line sy=1, sx=0 shows data 0x1280. Line at sy=479 issues no request.
- **Backpressure:** ready held low 10 cycles during REQ -> valid=1 and addr constant throughout; one acceptance only; no word lost or duplicated.
- **Underrun:** response latency set so a fetch exceeds 800 cycles -> next line trigger sets underrun=1 (stays 1). No request is issued for the dropped line; the in-flight fetch still completes.
- **Mid-burst reset:** rst_n pulsed after 3 of 8 responses -> valid=0 immediately. After release, no requests until the next frame, which restarts at FB_BASE.
